// File: rtl/ysyx_22050243_store_narrow.sv
// Store narrowing unit: places the low 1/2/4/8 operand bytes on an aligned write bus with strobes; MISALIGN_SPLIT_EN enables boundary-crossing splits.
// Latency: first beat valid the cycle after acceptance; done_o 3 cycles after acceptance for a single beat with ready/bvalid high.
// Backpressure: beat payload held until mem_ready_i; req_ready_o low until the write response completes the store.
module ysyx_22050243_store_narrow #(
    parameter int XLEN = 64,
    parameter int AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [XLEN-1:0]   req_data_i,
    input  logic [1:0]        req_size_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [AW-1:0]     mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic              mem_bvalid_i,
    output logic              done_o,
    output logic              misalign_o
);
    localparam int SW = XLEN / 8;

    typedef enum logic [2:0] {IDLE, BEAT0, RESP0, BEAT1, RESP1} state_t;

    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [SW-1:0]   wstrb;
    } beat_t;

    state_t state;
    beat_t  hi_q;

    logic [XLEN-1:0]   dmask;
    logic [SW-1:0]     bmask;
    logic [2*XLEN-1:0] win;
    logic [2*SW-1:0]   strb16;
    logic              reject;

    always_comb begin
        dmask = '0;
        bmask = '0;
        case (req_size_i)
            2'd0: begin dmask = XLEN'(64'h0000_0000_0000_00FF); bmask = SW'(8'h01); end
            2'd1: begin dmask = XLEN'(64'h0000_0000_0000_FFFF); bmask = SW'(8'h03); end
            2'd2: begin dmask = XLEN'(64'h0000_0000_FFFF_FFFF); bmask = SW'(8'h0F); end
            default: begin dmask = '1; bmask = '1; end
        endcase
        win    = {{XLEN{1'b0}}, req_data_i & dmask} << {req_addr_i[2:0], 3'b000};
        strb16 = {{SW{1'b0}}, bmask} << req_addr_i[2:0];
    end

`ifdef MISALIGN_SPLIT_EN
    assign reject = 1'b0;
`else
    logic [2:0] amask;

    always_comb begin
        amask = '0;
        case (req_size_i)
            2'd0:    amask = 3'd0;
            2'd1:    amask = 3'd1;
            2'd2:    amask = 3'd3;
            default: amask = 3'd7;
        endcase
    end

    assign reject = |(req_addr_i[2:0] & amask);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            done_o      <= 1'b0;
            misalign_o  <= 1'b0;
            hi_q        <= '0;
        end else begin
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    // ready is dropped on the done cycle, so re-arm it here
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        if (reject) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state       <= BEAT0;
                            req_ready_o <= 1'b0;
                            mem_valid_o <= 1'b1;
                            mem_addr_o  <= {req_addr_i[AW-1:3], 3'b000};
                            mem_wdata_o <= win[XLEN-1:0];
                            mem_wstrb_o <= strb16[SW-1:0];
                            hi_q.wdata  <= win[2*XLEN-1:XLEN];
                            hi_q.wstrb  <= strb16[2*SW-1:SW];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= RESP0;
                    end
                end
                RESP0: begin
                    if (mem_bvalid_i) begin
                        if (hi_q.wstrb == '0) begin
                            done_o <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state       <= BEAT1;
                            mem_valid_o <= 1'b1;
                            mem_addr_o  <= mem_addr_o + AW'(8);
                            mem_wdata_o <= hi_q.wdata;
                            mem_wstrb_o <= hi_q.wstrb;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        state       <= RESP1;
                    end
                end
                RESP1: begin
                    if (mem_bvalid_i) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22050243_store_narrow.sv
// Bench for ysyx_22050243_store_narrow: directed and random stores against a byte-level reference model.
module tb_ysyx_22050243_store_narrow;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [63:0] req_data_i;
    logic [1:0]  req_size_i;
    logic        mem_valid_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_bvalid_i;
    logic        done_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } xbeat_t;

    ysyx_22050243_store_narrow #(.XLEN(64), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_bvalid_i(mem_bvalid_i), .done_o(done_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scatter the operand byte by byte into the 8-byte words it touches.
    function automatic int model(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                                 output xbeat_t b0, output xbeat_t b1);
        int n = 1 << sz;
        int nb = 1;
        logic [31:0] ba;
        b0.addr = a & ~32'h7;
        b0.wdata = '0;
        b0.wstrb = '0;
        b1.addr = b0.addr + 32'd8;
        b1.wdata = '0;
        b1.wstrb = '0;
`ifndef MISALIGN_SPLIT_EN
        if ((a % n) != 0) return 0;
`endif
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if ((ba & ~32'h7) == b0.addr) begin
                b0.wdata[8*ba[2:0] +: 8] = d[8*i +: 8];
                b0.wstrb[ba[2:0]] = 1'b1;
            end else begin
                b1.wdata[8*ba[2:0] +: 8] = d[8*i +: 8];
                b1.wstrb[ba[2:0]] = 1'b1;
                nb = 2;
            end
        end
        return nb;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz,
                            input int rdly, input int bdly);
        xbeat_t b0, b1, e;
        int nb;
        int cyc;
        nb = model(a, d, sz, b0, b1);
        chk("ready_before_req", req_ready_o, 1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        req_size_i  = sz;
        tick();
        cyc = 1;
        req_valid_i = 1'b0;
        req_data_i  = {$urandom, $urandom};
        req_addr_i  = $urandom;
        if (nb == 0) begin
            chk("misalign_pulse", misalign_o, 1);
            chk("misalign_no_beat", mem_valid_o, 0);
            chk("misalign_no_done", done_o, 0);
            tick();
            chk("misalign_one_cycle", misalign_o, 0);
            chk("misalign_still_no_beat", mem_valid_o, 0);
            return;
        end
        chk("no_misalign", misalign_o, 0);
        for (int k = 0; k < nb; k++) begin
            e = (k == 0) ? b0 : b1;
            chk("beat_valid", mem_valid_o, 1);
            chk("beat_addr", mem_addr_o, e.addr);
            chk("beat_wdata", mem_wdata_o, e.wdata);
            chk("beat_wstrb", mem_wstrb_o, e.wstrb);
            for (int s = 0; s < rdly; s++) begin
                mem_bvalid_i = 1'($urandom_range(0, 1));
                tick();
                cyc++;
                chk("stall_valid", mem_valid_o, 1);
                chk("stall_addr", mem_addr_o, e.addr);
                chk("stall_wdata", mem_wdata_o, e.wdata);
                chk("stall_wstrb", mem_wstrb_o, e.wstrb);
                chk("stall_ready_low", req_ready_o, 0);
            end
            mem_bvalid_i = 1'b0;
            mem_ready_i  = 1'b1;
            tick();
            cyc++;
            mem_ready_i = 1'b0;
            chk("resp_valid_low", mem_valid_o, 0);
            chk("resp_ready_low", req_ready_o, 0);
            for (int s = 0; s < bdly; s++) begin
                mem_ready_i = 1'($urandom_range(0, 1));
                tick();
                cyc++;
                chk("bwait_valid_low", mem_valid_o, 0);
                chk("bwait_ready_low", req_ready_o, 0);
                chk("bwait_no_done", done_o, 0);
            end
            mem_ready_i  = 1'b0;
            mem_bvalid_i = 1'b1;
            tick();
            cyc++;
            mem_bvalid_i = 1'b0;
        end
        chk("done_pulse", done_o, 1);
        chk("done_valid_low", mem_valid_o, 0);
        chk("done_cycle_ready_low", req_ready_o, 0);
        if (rdly == 0 && bdly == 0 && nb == 1) chk("latency", 128'(cyc), 3);
        tick();
        chk("done_one_cycle", done_o, 0);
        chk("ready_after_done", req_ready_o, 1);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i = '0;
        req_data_i = '0;
        req_size_i = '0;
        mem_ready_i = 1'b0;
        mem_bvalid_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", req_ready_o, 1);
        chk("rst_valid", mem_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_wstrb", mem_wstrb_o, 0);
        rst = 1'b0;
        tick();

        do_store(32'h8000_0008, 64'h1122_3344_5566_7788, 2'd3, 0, 0);
        do_store(32'h8000_0003, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 0, 0);
        do_store(32'h8000_0006, 64'h0000_0000_DEAD_BEEF, 2'd2, 0, 0);
        do_store(32'h8000_0010, 64'h0123_4567_89AB_CDEF, 2'd1, 5, 4);
        do_store(32'h8000_0007, 64'h0000_0000_0000_005A, 2'd0, 1, 1);
        do_store(32'hFFFF_FFFF, 64'h0000_0000_0000_00C3, 2'd0, 0, 0);
        do_store(32'hFFFF_FFFF, 64'h0000_0000_0000_A55A, 2'd1, 0, 0);

        // Reset while waiting for the first write response.
        req_valid_i = 1'b1;
        req_addr_i  = 32'h8000_0020;
        req_data_i  = 64'hCAFE_F00D_1234_5678;
        req_size_i  = 2'd3;
        tick();
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick();
        mem_ready_i = 1'b0;
        chk("pre_rst_in_resp", mem_valid_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", req_ready_o, 1);
        chk("midrst_valid", mem_valid_o, 0);
        chk("midrst_done", done_o, 0);
        mem_bvalid_i = 1'b1;
        tick();
        mem_bvalid_i = 1'b0;
        chk("stray_bvalid_no_done", done_o, 0);
        chk("stray_bvalid_no_beat", mem_valid_o, 0);
        tick();

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            do_store(a, {$urandom, $urandom}, sz, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
